// File: rtl/mbist_march_ctrl_if.sv
// Counter and memory bus of the MBIST march sequencer.
// The controller takes the master side; the counter and memory wrapper take the slave side.
interface mbist_march_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d_in;
  logic              cnt_ld;
  logic              cnt_ud;
  logic              cnt_cen;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cnt_q, mem_rdata,
    output cnt_d_in, cnt_ld, cnt_ud, cnt_cen,
    output mem_addr, mem_en, mem_we, mem_wdata
  );

  modport slave (
    output cnt_q, mem_rdata,
    input  cnt_d_in, cnt_ld, cnt_ud, cnt_cen,
    input  mem_addr, mem_en, mem_we, mem_wdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: steps an external up/down address counter through six
// march elements, issues read/write ops and tracks the first read mismatch.
module mbist_march_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  mbist_march_ctrl_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  typedef enum logic [2:0] {IDLE, LOAD, OP1, OP2, FLUSH} state_t;

  state_t            state, state_nx;
  logic [2:0]        elem, elem_nx;
  logic              elem_up, elem_two, op1_bg, final_addr, rd_op;
  logic              rd_pend;
  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] exp_addr;
  logic [2:0]        exp_elem;

  // E3/E4 run downwards; E0 and E5 are single-op; op1 background is 1 in E2/E4, op2 is its inverse
  assign elem_up    = !((elem == 3'd3) || (elem == 3'd4));
  assign elem_two   = (elem != 3'd0) && (elem != 3'd5);
  assign op1_bg     = (elem == 3'd2) || (elem == 3'd4);
  assign final_addr = elem_up ? (bus.cnt_q == {ADDR_W{1'b1}}) : (bus.cnt_q == {ADDR_W{1'b0}});
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx      = state;
    elem_nx       = elem;
    rd_op         = 1'b0;
    bus.cnt_d_in  = '0;
    bus.cnt_ld    = 1'b0;
    bus.cnt_ud    = 1'b0;
    bus.cnt_cen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (state != IDLE) bus.mem_addr = bus.cnt_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          elem_nx  = 3'd0;
        end
      end
      LOAD: begin
        bus.cnt_ld   = 1'b1;
        bus.cnt_cen  = 1'b1;
        bus.cnt_ud   = elem_up;
        bus.cnt_d_in = elem_up ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
        state_nx     = OP1;
      end
      OP1: begin
        bus.cnt_ud = elem_up;
        bus.mem_en = 1'b1;
        if (elem == 3'd0) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = {DATA_W{op1_bg}};
        end else begin
          rd_op = 1'b1;
        end
        if (elem_two) begin
          state_nx = OP2;
        end else if (!final_addr) begin
          bus.cnt_cen = 1'b1;
        end else if (elem == 3'd5) begin
          state_nx = FLUSH;
        end else begin
          state_nx = LOAD;
          elem_nx  = elem + 3'd1;
        end
      end
      OP2: begin
        bus.cnt_ud    = elem_up;
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = {DATA_W{~op1_bg}};
        if (!final_addr) begin
          bus.cnt_cen = 1'b1;
          state_nx    = OP1;
        end else begin
          state_nx = LOAD;
          elem_nx  = elem + 3'd1;
        end
      end
      FLUSH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Reads are compared one cycle later, when mem_rdata is valid; only the first mismatch is latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      elem      <= 3'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 3'd0;
      rd_pend   <= 1'b0;
      exp_data  <= '0;
      exp_addr  <= '0;
      exp_elem  <= 3'd0;
    end else begin
      state   <= state_nx;
      elem    <= elem_nx;
      rd_pend <= rd_op;
      if (rd_op) begin
        exp_data <= {DATA_W{op1_bg}};
        exp_addr <= bus.cnt_q;
        exp_elem <= elem;
      end
      if ((state == IDLE) && start) begin
        done      <= 1'b0;
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= 3'd0;
      end else begin
        if (state == FLUSH) done <= 1'b1;
        if (rd_pend && (bus.mem_rdata != exp_data) && !fail) begin
          fail      <= 1'b1;
          fail_addr <= exp_addr;
          fail_elem <= exp_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Randomized self-checking bench for mbist_march_ctrl with a behavioural
// counter, a fault-injectable memory and a march-table reference model.
module tb_mbist_march_ctrl;

  localparam int AW       = 2;
  localparam int DW       = 8;
  localparam int N        = 1 << AW;
  localparam int EXP_BUSY = 10 * N + 7;
  localparam int EXP_OPS  = 10 * N;
  localparam int BOUND    = 300;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } op_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;

  mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  int errors = 0;
  int checks = 0;

  // March C- table: direction, op count, write flag and background per op
  bit elem_up [6]    = '{1, 1, 1, 0, 0, 1};
  int nops    [6]    = '{1, 2, 2, 2, 2, 1};
  bit op_we   [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit op_bg   [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  logic [DW-1:0] f1  [N];
  logic [DW-1:0] f0  [N];
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata_r;
  logic [AW-1:0] cq;

  op_t           exp_q[$];
  op_t           obs_q[$];
  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [2:0]    exp_felem;
  int            addr_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural counter; rst_n deliberately does not touch it
  always @(posedge clk) begin
    if (bus.cnt_cen) begin
      if (bus.cnt_ld) cq <= bus.cnt_d_in;
      else if (bus.cnt_ud) cq <= cq + 1'b1;
      else cq <= cq - 1'b1;
    end
  end
  assign bus.cnt_q = cq;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else rdata_r <= (mem[bus.mem_addr] | f1[bus.mem_addr]) & ~f0[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_r;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_en === 1'b1)
      obs_q.push_back(op_t'{bus.mem_addr, bus.mem_we, bus.mem_wdata});
    if (busy === 1'b1 && bus.mem_addr !== cq)
      addr_err++;
  end

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      f1[i] = '0;
      f0[i] = '0;
    end
  endtask

  // Walks the march table over an ideal array with the injected faults applied on read
  function automatic void build_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] bgw, rv;
    int a;
    exp_q.delete();
    exp_fail  = 1'b0;
    exp_faddr = '0;
    exp_felem = 3'd0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = elem_up[e] ? i : N - 1 - i;
        for (int o = 0; o < nops[e]; o++) begin
          bgw = {DW{op_bg[e][o]}};
          if (op_we[e][o]) begin
            m[a] = bgw;
          end else begin
            rv = (m[a] | f1[a]) & ~f0[a];
            if (rv !== bgw && !exp_fail) begin
              exp_fail  = 1'b1;
              exp_faddr = a[AW-1:0];
              exp_felem = e[2:0];
            end
          end
          exp_q.push_back(op_t'{a[AW-1:0], op_we[e][o], op_we[e][o] ? bgw : '0});
        end
      end
    end
  endfunction

  function automatic int op_mismatches();
    int bad, n;
    bad = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                        : exp_q.size() - obs_q.size();
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].we !== exp_q[i].we ||
          (exp_q[i].we && obs_q[i].data !== exp_q[i].data))
        bad++;
    end
    return bad;
  endfunction

  task automatic applyStimulus(input int pulse_at, output int cycles, output bit timed_out);
    obs_q.delete();
    addr_err = 0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < BOUND) begin
      cycles++;
      start = (cycles == pulse_at);
      @(negedge clk);
    end
    start     = 1'b0;
    timed_out = (cycles >= BOUND);
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.cnt_d_in, bus.cnt_ld, bus.cnt_ud, bus.cnt_cen, bus.mem_addr,
            bus.mem_en, bus.mem_we, bus.mem_wdata, busy, done, fail, fail_addr, fail_elem};
    checks++;
    if (outs !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %0h expected 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, bus.mem_en, bus.cnt_cen} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %b expected 000", {busy, bus.mem_en, bus.cnt_cen});
    end
  endtask

  task automatic test_fault_free();
    int cyc; bit to; int bad;
    clear_faults();
    build_model();
    applyStimulus(-1, cyc, to);
    bad = op_mismatches();
    checks++;
    if (to !== 1'b0 || cyc !== EXP_BUSY) begin
      errors++;
      $display("[TB] FAIL ff_busy_cycles: got %0d expected %0d", cyc, EXP_BUSY);
    end
    checks++;
    if ({done, fail} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ff_done_fail: got %b expected 10", {done, fail});
    end
    checks++;
    if (obs_q.size() !== EXP_OPS) begin
      errors++;
      $display("[TB] FAIL ff_op_count: got %0d expected %0d", obs_q.size(), EXP_OPS);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL ff_op_sequence: got %0d bad ops expected 0", bad);
    end
    checks++;
    if (addr_err !== 0) begin
      errors++;
      $display("[TB] FAIL ff_addr_follows_cnt: got %0d diffs expected 0", addr_err);
    end
  endtask

  task automatic test_stuck_faults();
    int cyc; bit to;
    clear_faults();
    f1[2] = 8'h01;
    build_model();
    applyStimulus(-1, cyc, to);
    checks++;
    if ({to, cyc} !== {1'b0, EXP_BUSY}) begin
      errors++;
      $display("[TB] FAIL sa1_busy_cycles: got %0d expected %0d", cyc, EXP_BUSY);
    end
    checks++;
    if ({done, fail, fail_addr, fail_elem} !== {1'b1, 1'b1, 2'd2, 3'd1}) begin
      errors++;
      $display("[TB] FAIL sa1_report: got done=%b fail=%b addr=%0d elem=%0d expected 1 1 2 1",
               done, fail, fail_addr, fail_elem);
    end
    clear_faults();
    f0[3] = 8'hFF;
    build_model();
    applyStimulus(-1, cyc, to);
    checks++;
    if ({fail, fail_addr, fail_elem} !== {1'b1, 2'd3, 3'd2}) begin
      errors++;
      $display("[TB] FAIL sa0_report: got fail=%b addr=%0d elem=%0d expected 1 3 2",
               fail, fail_addr, fail_elem);
    end
  endtask

  task automatic test_start_ignored();
    int cyc; bit to; int bad;
    clear_faults();
    build_model();
    applyStimulus(10, cyc, to);
    bad = op_mismatches();
    checks++;
    if (to !== 1'b0 || cyc !== EXP_BUSY) begin
      errors++;
      $display("[TB] FAIL restart_busy_cycles: got %0d expected %0d", cyc, EXP_BUSY);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL restart_op_sequence: got %0d bad ops expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit to; int bad; int stray;
    logic [15:0] outs;
    clear_faults();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (26) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {bus.cnt_ld, bus.cnt_cen, bus.cnt_ud, bus.mem_en, bus.mem_we, bus.mem_addr,
            busy, done, fail, fail_elem, 2'b00};
    checks++;
    if (outs !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got %0h expected 0", outs);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_en !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.mem_en !== 1'b0) stray++;
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_no_mem_ops: got %0d cycles expected 0", stray);
    end
    build_model();
    applyStimulus(-1, cyc, to);
    bad = op_mismatches();
    checks++;
    if (to !== 1'b0 || cyc !== EXP_BUSY || bad !== 0) begin
      errors++;
      $display("[TB] FAIL midrst_rerun: got cycles=%0d bad=%0d expected %0d 0", cyc, bad, EXP_BUSY);
    end
    checks++;
    if ({done, fail} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midrst_rerun_status: got %b expected 10", {done, fail});
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; int a;
    clear_faults();
    a = $urandom_range(1, N - 1);
    f1[a] = 8'($urandom_range(1, 255));
    applyStimulus(-1, cyc, to);
    checks++;
    if ({fail, fail_addr} !== {1'b1, a[AW-1:0]}) begin
      errors++;
      $display("[TB] FAIL b2b_first_fail: got fail=%b addr=%0d expected 1 %0d", fail, fail_addr, a);
    end
    clear_faults();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, fail, fail_addr, fail_elem} !== {1'b1, 1'b0, 1'b0, 2'd0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL b2b_clear_on_start: got busy=%b done=%b fail=%b addr=%0d elem=%0d expected 1 0 0 0 0",
               busy, done, fail, fail_addr, fail_elem);
    end
    cyc = 1;
    while (busy === 1'b1 && cyc < BOUND) begin
      @(negedge clk);
      if (busy === 1'b1) cyc++;
    end
    checks++;
    if (cyc !== EXP_BUSY || {done, fail} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_clean_rerun: got cycles=%0d done/fail=%b expected %0d 10",
               cyc, {done, fail}, EXP_BUSY);
    end
  endtask

  task automatic checkOutput(input int iter);
    int bad;
    bad = op_mismatches();
    checks++;
    if ({fail, fail_addr, fail_elem} !== {exp_fail, exp_faddr, exp_felem}) begin
      errors++;
      $display("[TB] FAIL rand%0d_report: got fail=%b addr=%0d elem=%0d expected %b %0d %0d",
               iter, fail, fail_addr, fail_elem, exp_fail, exp_faddr, exp_felem);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL rand%0d_op_sequence: got %0d bad ops expected 0", iter, bad);
    end
  endtask

  task automatic test_random_faults();
    int cyc; bit to; int nf; int a; logic [DW-1:0] mask;
    for (int it = 0; it < 8; it++) begin
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int k = 0; k < nf; k++) begin
        a    = $urandom_range(0, N - 1);
        mask = 8'($urandom_range(1, 255));
        if ($urandom_range(0, 1) == 1) f1[a] = f1[a] | mask;
        else f0[a] = f0[a] | mask;
      end
      build_model();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(-1, cyc, to);
      checks++;
      if (to !== 1'b0 || cyc !== EXP_BUSY || done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rand%0d_timing: got cycles=%0d done=%b expected %0d 1", it, cyc, done, EXP_BUSY);
      end
      checkOutput(it);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cq    = 2'($urandom_range(0, N - 1));
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
    rdata_r = '0;
    clear_faults();
    test_reset();
    test_fault_free();
    test_stuck_faults();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random_faults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
